// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants and scheduler state encoding shared by alu_sched.
// State MUL exists only when ALU_SCHED_MUL_EN is defined.
package cpu_pkg;
  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
`ifdef ALU_SCHED_MUL_EN
    CAPTURE,
    MUL
`else
    CAPTURE
`endif
  } state_e;
endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: requester, response and shared-ALU signals of the scheduler.
interface alu_sched_if;
  logic       REQ0, REQ1;
  logic [7:0] D1_0, D2_0, D1_1, D2_1;
  logic [2:0] SEL0, SEL1;
  logic       GNT0, GNT1;
  logic [7:0] ALU_DATA1, ALU_DATA2;
  logic [2:0] ALU_SELECT;
  logic [7:0] ALU_RESULT;
  logic       ALU_ZERO;
  logic [7:0] RESULT;
  logic       ZERO, RESP_ID, RESP_VALID, ERR, BUSY;
  modport slave (
    input  REQ0, REQ1, D1_0, D2_0, D1_1, D2_1, SEL0, SEL1, ALU_RESULT, ALU_ZERO,
    output GNT0, GNT1, ALU_DATA1, ALU_DATA2, ALU_SELECT, RESULT, ZERO, RESP_ID,
           RESP_VALID, ERR, BUSY
  );
  modport master (
    output REQ0, REQ1, D1_0, D2_0, D1_1, D2_1, SEL0, SEL1, ALU_RESULT, ALU_ZERO,
    input  GNT0, GNT1, ALU_DATA1, ALU_DATA2, ALU_SELECT, RESULT, ZERO, RESP_ID,
           RESP_VALID, ERR, BUSY
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; i_last names the requester granted last.
module rr_arb2 (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last,
  output logic [1:0] o_gnt
);
  assign o_gnt[0] = i_req0 & (~i_req1 | i_last);
  assign o_gnt[1] = i_req1 & (~i_req0 | ~i_last);
endmodule

// File: rtl/alu_sched.sv
// alu_sched: schedules two requesters onto one shared ALU with settle timing.
// Macro ALU_SCHED_MUL_EN adds opcode 100 (multiply by repeated ALU add).
module alu_sched
  import cpu_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input logic        CLK,
  input logic        RESET,
  alu_sched_if.slave bus
);
  localparam logic [3:0] SET_LOAD = 4'(SETTLE_CYC - 1);
  state_e     r_state;
  logic       r_gnt0, r_gnt1, r_gid, r_id, r_rv, r_err, r_zero, r_last;
  logic [7:0] r_d1, r_d2, r_res, r_a1, r_a2;
  logic [2:0] r_sel, r_asel;
  logic [3:0] r_set;
  logic [1:0] w_gnt;
`ifdef ALU_SCHED_MUL_EN
  logic [7:0] r_acc;
`endif
  rr_arb2 u_arb (.i_req0(bus.REQ0), .i_req1(bus.REQ1), .i_last(r_last), .o_gnt(w_gnt));
  assign bus.GNT0       = r_gnt0;
  assign bus.GNT1       = r_gnt1;
  assign bus.ALU_DATA1  = r_a1;
  assign bus.ALU_DATA2  = r_a2;
  assign bus.ALU_SELECT = r_asel;
  assign bus.RESULT     = r_res;
  assign bus.ZERO       = r_zero;
  assign bus.RESP_ID    = r_id;
  assign bus.RESP_VALID = r_rv;
  assign bus.ERR        = r_err;
  assign bus.BUSY       = r_state != IDLE;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_gid   <= 1'b0;
      r_id    <= 1'b0;
      r_rv    <= 1'b0;
      r_err   <= 1'b0;
      r_zero  <= 1'b0;
      r_last  <= 1'b1;
      r_d1    <= '0;
      r_d2    <= '0;
      r_res   <= '0;
      r_a1    <= '0;
      r_a2    <= '0;
      r_sel   <= '0;
      r_asel  <= '0;
      r_set   <= '0;
`ifdef ALU_SCHED_MUL_EN
      r_acc   <= '0;
`endif
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_rv   <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: if (|w_gnt) begin
          r_gnt0  <= w_gnt[0];
          r_gnt1  <= w_gnt[1];
          r_last  <= w_gnt[1];
          r_gid   <= w_gnt[1];
          r_d1    <= w_gnt[1] ? bus.D1_1 : bus.D1_0;
          r_d2    <= w_gnt[1] ? bus.D2_1 : bus.D2_0;
          r_sel   <= w_gnt[1] ? bus.SEL1 : bus.SEL0;
`ifdef ALU_SCHED_MUL_EN
          r_acc   <= '0;
`endif
          r_state <= ISSUE;
        end
        ISSUE: begin
`ifdef ALU_SCHED_MUL_EN
          // r_d2 doubles as the remaining-iteration count; zero here only on entry
          if (r_sel == OP_MUL) begin
            if (r_d2 == '0) begin
              r_res   <= '0;
              r_zero  <= 1'b1;
              r_id    <= r_gid;
              r_rv    <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_a1    <= r_acc;
              r_a2    <= r_d1;
              r_asel  <= OP_ADD;
              r_set   <= SET_LOAD;
              r_state <= SETTLE;
            end
          end else
`endif
          if (r_sel > OP_OR) begin
            r_res   <= '0;
            r_zero  <= 1'b1;
            r_err   <= 1'b1;
            r_id    <= r_gid;
            r_rv    <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_a1    <= r_d1;
            r_a2    <= r_d2;
            r_asel  <= r_sel;
            r_set   <= SET_LOAD;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          r_set   <= r_set - 4'd1;
          r_state <= r_set == '0 ? CAPTURE : SETTLE;
        end
        CAPTURE: begin
`ifdef ALU_SCHED_MUL_EN
          if (r_sel == OP_MUL) begin
            r_acc   <= bus.ALU_RESULT;
            r_d2    <= r_d2 - 8'd1;
            r_state <= MUL;
          end else
`endif
          begin
            r_res   <= bus.ALU_RESULT;
            r_zero  <= bus.ALU_ZERO;
            r_id    <= r_gid;
            r_rv    <= 1'b1;
            r_state <= IDLE;
          end
        end
`ifdef ALU_SCHED_MUL_EN
        MUL: if (r_d2 == '0) begin
          r_res   <= r_acc;
          r_zero  <= r_acc == '0;
          r_id    <= r_gid;
          r_rv    <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_state <= ISSUE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: randomized bench for alu_sched against a transaction-level model
// with a combinational ALU stub; directed cases pin the model with literal values.
module tb_alu_sched;
  localparam int S = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  alu_sched_if bus();
  alu_sched #(.SETTLE_CYC(S)) dut (.CLK(clk), .RESET(rst), .bus(bus));
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      3'd0:    return a;
      3'd1:    return a + b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return 8'h00;
    endcase
  endfunction
  assign bus.ALU_RESULT = alu_f(bus.ALU_DATA1, bus.ALU_DATA2, bus.ALU_SELECT);
  assign bus.ALU_ZERO   = bus.ALU_RESULT == 8'h00;
  // lat < 0 means completion time is not fixed by the rules (multi-iteration multiply)
  function automatic void model_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                                   output logic [7:0] res, output bit err, output int lat);
    res = 8'h00;
    err = 1'b0;
    lat = S + 2;
    if (s < 3'd4) res = alu_f(a, b, s);
`ifdef ALU_SCHED_MUL_EN
    else if (s == 3'd4) begin
      res = 8'(int'(a) * int'(b));
      lat = (b == 8'h00) ? 1 : -1;
    end
`endif
    else begin
      err = 1'b1;
      lat = 1;
    end
  endfunction
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  initial begin : cmp
    int cyc;
    int free_at;
    int resp_cyc;
    int lat;
    bit last, pend, exact, s_rst, s_r0, s_r1, w, e_g0, e_g1, rv_exp, e_err, e_id, h_zero, h_id;
    logic [7:0] s_a0, s_b0, s_a1, s_b1, e_res, h_res;
    logic [2:0] s_s0, s_s1;
    cyc = 0; free_at = 0; resp_cyc = 0; last = 1'b1; pend = 1'b0; exact = 1'b1;
    h_res = 8'h00; h_zero = 1'b0; h_id = 1'b0; e_res = 8'h00; e_err = 1'b0; e_id = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      s_rst = rst; s_r0 = bus.REQ0; s_r1 = bus.REQ1;
      s_a0 = bus.D1_0; s_b0 = bus.D2_0; s_s0 = bus.SEL0;
      s_a1 = bus.D1_1; s_b1 = bus.D2_1; s_s1 = bus.SEL1;
      @(negedge clk);
      if (s_rst) begin
        last = 1'b1; pend = 1'b0; free_at = cyc + 1;
        h_res = 8'h00; h_zero = 1'b0; h_id = 1'b0;
        chk("rst_gnt", 8'({bus.GNT1, bus.GNT0}), 8'd0);
        chk("rst_rv_err_busy", 8'({bus.RESP_VALID, bus.ERR, bus.BUSY}), 8'd0);
        chk("rst_result", bus.RESULT, 8'h00);
        chk("rst_alu_sel", 8'(bus.ALU_SELECT), 8'd0);
      end else begin
        e_g0 = 1'b0; e_g1 = 1'b0;
        if (!pend && cyc >= free_at && (s_r0 || s_r1)) begin
          w = s_r1 && (!s_r0 || !last);
          e_g0 = !w; e_g1 = w; last = w; e_id = w; pend = 1'b1;
          model_op(w ? s_a1 : s_a0, w ? s_b1 : s_b0, w ? s_s1 : s_s0, e_res, e_err, lat);
          exact = lat > 0;
          resp_cyc = cyc + (exact ? lat : 3000);
        end
        if (pend && !exact && cyc >= resp_cyc) begin
          chk("mul_deadline", 8'd0, 8'd1);
          pend = 1'b0;
          free_at = cyc + 1;
        end
        rv_exp = pend && (exact ? cyc == resp_cyc : bus.RESP_VALID === 1'b1);
        if (rv_exp) begin
          h_res = e_res; h_zero = e_res == 8'h00; h_id = e_id;
          pend = 1'b0;
          free_at = cyc + 1;
        end
        chk("gnt0", 8'(bus.GNT0), 8'(e_g0));
        chk("gnt1", 8'(bus.GNT1), 8'(e_g1));
        chk("resp_valid", 8'(bus.RESP_VALID), 8'(rv_exp));
        chk("err", 8'(bus.ERR), 8'(rv_exp & e_err));
        chk("busy", 8'(bus.BUSY), 8'(pend));
        chk("result", bus.RESULT, h_res);
        chk("zero", 8'(bus.ZERO), 8'(h_zero));
        chk("resp_id", 8'(bus.RESP_ID), 8'(h_id));
      end
    end
  end
  task automatic set_req(input bit id, input bit v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    if (id) begin
      bus.REQ1 = v; bus.D1_1 = a; bus.D2_1 = b; bus.SEL1 = s;
    end else begin
      bus.REQ0 = v; bus.D1_0 = a; bus.D2_0 = b; bus.SEL0 = s;
    end
  endtask
  task automatic wait_gnt(input bit id);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(id ? bus.GNT1 : bus.GNT0) && n < 50);
    chk("gnt_seen", 8'(id ? bus.GNT1 : bus.GNT0), 8'd1);
  endtask
  task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s, output int lat);
    set_req(id, 1'b1, a, b, s);
    wait_gnt(id);
    set_req(id, 1'b0, a, b, s);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.RESP_VALID && lat < 5000);
    chk("rv_seen", 8'(bus.RESP_VALID), 8'd1);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.BUSY && n < 5000);
    chk("idle_seen", 8'(bus.BUSY), 8'd0);
  endtask
  task automatic pulse_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
  endtask
  initial begin : drv
    int lat;
    int n;
    int ids[$];
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    bus.D1_0 = '0; bus.D2_0 = '0; bus.D1_1 = '0; bus.D2_1 = '0;
    bus.SEL0 = '0; bus.SEL1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_result", bus.RESULT, 8'h00);
    chk("init_busy", 8'(bus.BUSY), 8'd0);
    chk("init_alu_d1", bus.ALU_DATA1, 8'h00);
    rst = 1'b0;
    set_req(1'b0, 1'b1, 8'h05, 8'h03, 3'b001);
    @(posedge clk); #1;
    chk("add_gnt0", 8'(bus.GNT0), 8'd1);
    bus.REQ0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("add_rv", 8'(bus.RESP_VALID), 8'd1);
    chk("add_result", bus.RESULT, 8'h08);
    chk("add_zero_id_err", 8'({bus.ZERO, bus.RESP_ID, bus.ERR}), 8'd0);
    do_op(1'b0, 8'hF0, 8'h0F, 3'b010, lat);
    chk("and_result", bus.RESULT, 8'h00);
    chk("and_zero", 8'(bus.ZERO), 8'd1);
    chk("and_err", 8'(bus.ERR), 8'd0);
    chk("and_lat", 8'(lat), 8'd3);
    do_op(1'b1, 8'h07, 8'h06, 3'b100, lat);
`ifdef ALU_SCHED_MUL_EN
    chk("mul_result", bus.RESULT, 8'h2A);
    chk("mul_zero_err", 8'({bus.ZERO, bus.ERR}), 8'd0);
`else
    chk("byp_result", bus.RESULT, 8'h00);
    chk("byp_zero_err", 8'({bus.ZERO, bus.ERR}), 8'd3);
    chk("byp_lat", 8'(lat), 8'd1);
`endif
    chk("op100_id", 8'(bus.RESP_ID), 8'd1);
    do_op(1'b0, 8'h07, 8'h00, 3'b100, lat);
    chk("d2zero_result", bus.RESULT, 8'h00);
    chk("d2zero_lat", 8'(lat), 8'd1);
`ifdef ALU_SCHED_MUL_EN
    chk("d2zero_zero_err", 8'({bus.ZERO, bus.ERR}), 8'd2);
`else
    chk("d2zero_zero_err", 8'({bus.ZERO, bus.ERR}), 8'd3);
`endif
    do_op(1'b1, 8'h12, 8'h34, 3'b111, lat);
    chk("op111_err", 8'({bus.ZERO, bus.ERR}), 8'd3);
    chk("op111_lat", 8'(lat), 8'd1);
    pulse_reset();
    set_req(1'b0, 1'b1, 8'h11, 8'h22, 3'b001);
    set_req(1'b1, 1'b1, 8'h40, 8'h02, 3'b011);
    n = 0;
    while (ids.size() < 4 && n < 200) begin
      @(posedge clk); #1; n++;
      if (bus.GNT0) ids.push_back(0);
      if (bus.GNT1) ids.push_back(1);
    end
    chk("rr_count", 8'(ids.size()), 8'd4);
    for (int i = 0; i < 4 && i < ids.size(); i++) chk("rr_order", 8'(ids[i]), 8'(i % 2));
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    wait_idle();
    set_req(1'b1, 1'b1, 8'h21, 8'h10, 3'b001);
    wait_gnt(1'b1);
    bus.REQ1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_pre", 8'(bus.BUSY), 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_gnt", 8'({bus.GNT1, bus.GNT0}), 8'd0);
    chk("abort_rv_err_busy", 8'({bus.RESP_VALID, bus.ERR, bus.BUSY}), 8'd0);
    chk("abort_result", bus.RESULT, 8'h00);
    chk("abort_zero_id", 8'({bus.ZERO, bus.RESP_ID}), 8'd0);
    chk("abort_alu_d1", bus.ALU_DATA1, 8'h00);
    @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    set_req(1'b0, 1'b1, 8'h03, 8'h04, 3'b001);
    set_req(1'b1, 1'b1, 8'h05, 8'h06, 3'b001);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(bus.GNT0 || bus.GNT1) && n < 50);
    chk("post_rst_gnt", 8'({bus.GNT1, bus.GNT0}), 8'd1);
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    wait_idle();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      set_req(1'b0, $urandom_range(0, 9) < 4, 8'($urandom), 8'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      set_req(1'b1, $urandom_range(0, 9) < 4, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
    end
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
